ram_initiator: RTL

RAM_INITIATOR -- requirements
Module: ram_initiator

---
 rtl/mem_pkg.sv | 15 +
 rtl/ram_initiator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding and default geometry for the RAM initiator.
package mem_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 12;
    localparam int unsigned BURST_LEN_WIDTH       = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_initiator.sv
// Command-driven burst initiator for a single-port RAM with falling-edge read data.
// Bursts (req_len) are honoured only when RAM_INITIATOR_BURST_EN is defined; otherwise every request is one word.
module ram_initiator
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDRESS_WIDTH-1:0]   req_addr,
    input  logic [BURST_LEN_WIDTH-1:0] req_len,
    input  logic                       wdata_valid,
    output logic                       wdata_ready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_last,
    output logic                       busy,
    output logic                       ram_wEn,
    output logic [ADDRESS_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]      ram_dataIn,
    input  logic [DATA_WIDTH-1:0]      ram_dataOut
);

`ifdef RAM_INITIATOR_BURST_EN
    localparam logic [BURST_LEN_WIDTH-1:0] LEN_MASK = '1;
`else
    localparam logic [BURST_LEN_WIDTH-1:0] LEN_MASK = '0;
`endif

    state_e                       state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
    logic [BURST_LEN_WIDTH-1:0]   beats_q, beats_d;
    logic                         req_ready_q, req_ready_d;
    logic                         wdata_ready_q, wdata_ready_d;
    logic                         busy_q, busy_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_last_q, rsp_last_d;
    logic [DATA_WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic                         ram_wen_q, ram_wen_d;
    logic [ADDRESS_WIDTH-1:0]     ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]        ram_data_in_q, ram_data_in_d;

    logic [ADDRESS_WIDTH-1:0]     addr_inc;
    logic [BURST_LEN_WIDTH-1:0]   beats_dec;
    logic                         last_beat;

    assign addr_inc  = ADDRESS_WIDTH'(addr_q + 1'b1);
    assign beats_dec = BURST_LEN_WIDTH'(beats_q - 1'b1);
    assign last_beat = (beats_q == '0);

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beats_d       = beats_q;
        ram_wen_d     = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_last_d    = rsp_last_q;
        rsp_data_d    = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    beats_d = req_len & LEN_MASK;
                    if (req_write) begin
                        state_d = ST_WR;
                    end else begin
                        state_d    = ST_RD_ISSUE;
                        ram_addr_d = req_addr;
                    end
                end
            end
            ST_WR: begin
                if (wdata_valid && wdata_ready_q) begin
                    ram_wen_d     = 1'b1;
                    ram_addr_d    = addr_q;
                    ram_data_in_d = wdata;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_inc;
                        beats_d = beats_dec;
                    end
                end
            end
            ST_RD_ISSUE: begin
                // RAM has presented the word on the falling edge of this cycle
                rsp_data_d  = ram_dataOut;
                rsp_valid_d = 1'b1;
                rsp_last_d  = last_beat;
                state_d     = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d     = addr_inc;
                        beats_d    = beats_dec;
                        ram_addr_d = addr_inc;
                        state_d    = ST_RD_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d   = (state_d == ST_IDLE);
        wdata_ready_d = (state_d == ST_WR);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            beats_q       <= '0;
            req_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
            rsp_data_q    <= '0;
            ram_wen_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beats_q       <= beats_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            busy_q        <= busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_last_q    <= rsp_last_d;
            rsp_data_q    <= rsp_data_d;
            ram_wen_q     <= ram_wen_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_last    = rsp_last_q;
    assign rsp_data    = rsp_data_q;
    assign ram_wEn     = ram_wen_q;
    assign ram_addr    = ram_addr_q;
    assign ram_dataIn  = ram_data_in_q;

endmodule
